mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, memory address width.
REQ-002 Parameter DATA_W, 16, memory word width.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_req  input  1  instruction-fetch read request; held until fetch_ack.
REQ-006 fetch_addr  input  ADDR_W  fetch address; stable while fetch_req high.
REQ-007 fetch_ack  output  1  one-cycle pulse; fetch_data valid.
REQ-008 fetch_data  output  DATA_W  registered fetched word.
REQ-009 data_req  input  1  load/store request; held until data_ack.
REQ-010 data_we  input  1  1 = store, 0 = load; stable while data_req high.
REQ-011 data_addr  input  ADDR_W  load/store address.
REQ-012 data_wdata  input  DATA_W  store data.
REQ-013 data_ack  output  1  one-cycle pulse; load data valid / store done.
REQ-014 data_rdata  output  DATA_W  registered load word.
REQ-015 mem_enable, mem_write_enable  output  1 each  memory enable / write enable.
REQ-016 mem_address  output  ADDR_W; mem_write_data  output  DATA_W; mem_read_data  input  DATA_W (async-read memory output).
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, GRANT_FETCH, GRANT_DATA, ACK.
REQ-019 IDLE: no request -> stay; request(s) pending -> winner's state; winner's address/write-enable/write-data SHALL be registered on that edge.
REQ-020 Fixed priority (macro absent): data_req SHALL win over fetch_req.
REQ-021 GRANT_x: mem_enable=1, mem_address/mem_write_data from registers, mem_write_enable=1 only for a data store; fetch SHALL never write.
REQ-022 On the edge ending GRANT_x: the store commits in memory; for a read, mem_read_data SHALL be captured into fetch_data or data_rdata; next state ACK.
REQ-023 ACK: the granted port's ack SHALL be 1 for exactly this cycle; requests SHALL NOT be sampled; next state IDLE.
REQ-024 Latency: request high in cycle N (FSM in IDLE) -> ack in cycle N+2; peak throughput 1 access per 3 cycles.
REQ-025 Outside GRANT_x, mem_enable, mem_write_enable, mem_address and mem_write_data SHALL all be 0.
REQ-026 fetch_data/data_rdata SHALL hold their value until that port's next read ack; a store SHALL NOT change data_rdata.
REQ-027 Losing request SHALL remain pending and be served next IDLE; no request is dropped.
REQ-028 Address wrap is not applicable: addresses pass through unmodified, 0xFF valid.

Reset
REQ-029 Reset SHALL force IDLE, all outputs 0, the registered address/data to 0, and last-grant to DATA.
REQ-030 Reset during GRANT_x: the in-flight store still commits at that edge (memory has no reset); no ack SHALL be issued.
REQ-031 Reset has priority over every transition.

Configuration
REQ-032 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted last wins; last-grant updates on each grant.
REQ-033 Macro undefined: fixed data-over-fetch priority (REQ-020); last-grant register omitted.

Structure
REQ-034 Package mem_arbiter_pkg: state enum, grant-id type (FETCH/DATA), ADDR_W/DATA_W defaults.
REQ-035 Sub-module mem_arb_select: combinational winner selection, holding the macro-dependent priority logic.

Verification
REQ-036 Fetch 0x10 (mem[0x10]=0x1234) -> mem_enable in cycle N+1, fetch_ack and fetch_data=0x1234 in N+2.
REQ-037 Store 0xBEEF to 0x20, then load 0x20 -> mem_write_enable one cycle only, then data_rdata=0xBEEF, data_ack twice total.
REQ-038 Simultaneous fetch 0x01 and load 0x02, macro off -> data served first, fetch acked 3 cycles later; repeated contention always data first.
REQ-039 Macro on, continuous contention -> first grant FETCH, then alternating DATA, FETCH, ...
REQ-040 Reset asserted in GRANT_DATA store to 0xFF -> mem[0xFF] updated, no data_ack, FSM IDLE, all outputs 0 next cycle.
REQ-041 Load from 0xFF returning 0xA5A5 followed by store -> data_rdata stays 0xA5A5 after the store.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// MEM_ARBITER_ROUND_ROBIN_EN switches contention handling from fixed to round-robin.
package mem_arbiter_pkg;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StGrantFetch,
    StGrantData,
    StAck
  } state_e;

  typedef enum logic {
    GrantFetch = 1'b0,
    GrantData  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between the fetch and data ports.
// MEM_ARBITER_ROUND_ROBIN_EN: contention goes to the port not granted last; otherwise data wins.
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic fetch_req,
  input  logic data_req,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic last_grant_data,
`endif
  output logic grant_valid,
  output logic grant_data
);

  always_comb begin
    grant_valid = fetch_req | data_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    if (fetch_req && data_req) begin
      grant_data = ~last_grant_data;
    end else begin
      grant_data = data_req;
    end
`else
    grant_data = data_req;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single async-read memory.
// Build with MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is data-over-fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_e state_q;
  logic   sel_valid;
  logic   sel_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  grant_e last_grant_q;
`endif

  mem_arb_select u_select (
    .fetch_req       (fetch_req),
    .data_req        (data_req),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    .last_grant_data (last_grant_q == GrantData),
`endif
    .grant_valid     (sel_valid),
    .grant_data      (sel_data)
  );

  // The mem_* outputs double as the registered grant address/write data, so they
  // are loaded when a grant starts and cleared when it ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      fetch_ack        <= 1'b0;
      fetch_data       <= '0;
      data_ack         <= 1'b0;
      data_rdata       <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_q     <= GrantData;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            busy       <= 1'b1;
            mem_enable <= 1'b1;
            if (sel_data) begin
              state_q          <= StGrantData;
              mem_address      <= data_addr;
              mem_write_enable <= data_we;
              mem_write_data   <= data_wdata;
            end else begin
              state_q          <= StGrantFetch;
              mem_address      <= fetch_addr;
              mem_write_enable <= 1'b0;
              mem_write_data   <= '0;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_q <= sel_data ? GrantData : GrantFetch;
`endif
          end
        end
        StGrantFetch: begin
          fetch_data       <= mem_read_data;
          fetch_ack        <= 1'b1;
          mem_enable       <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_address      <= '0;
          mem_write_data   <= '0;
          state_q          <= StAck;
        end
        StGrantData: begin
          // A store completes in memory on this edge and leaves data_rdata alone.
          if (!mem_write_enable) begin
            data_rdata <= mem_read_data;
          end
          data_ack         <= 1'b1;
          mem_enable       <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_address      <= '0;
          mem_write_data   <= '0;
          state_q          <= StAck;
        end
        StAck: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ack;
  logic [DW-1:0] fetch_data;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_ack;
  logic [DW-1:0] data_rdata;
  logic          mem_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ack        (fetch_ack),
    .fetch_data       (fetch_data),
    .data_req         (data_req),
    .data_we          (data_we),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_ack         (data_ack),
    .data_rdata       (data_rdata),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
  );

  // Memory attached to the arbiter: async read, write on the clock edge, no reset.
  logic [DW-1:0] mem [256];
  assign mem_read_data = mem[mem_address];
  always @(posedge clock) begin
    if (mem_enable && mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: one access every 3 cycles, ack 2 cycles after the grant cycle.
  typedef struct {
    bit            is_data;
    bit            is_store;
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [256];
  int            g_cyc = -100;
  int            next_free = 0;
  bit            last_data = 1'b1;
  logic [AW-1:0] g_addr = '0;
  logic          g_we = 1'b0;
  logic [DW-1:0] g_wdata = '0;
  logic [DW-1:0] m_fdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            mon_en = 1'b0;
  bit            ack_log[$];
  int            f_ack_cyc = 0;
  int            d_ack_cyc = 0;
  int            we_cycles = 0;
  int            d_acks = 0;

  always @(negedge clock) begin : model_monitor
    exp_t e;
    bit   win_data;
    bit   exp_me;
    bit   busy_exp;
    if (mon_en) begin
      if (fetch_ack || data_ack) begin
        ack_log.push_back(data_ack);
        if (data_ack) begin
          d_ack_cyc = cyc;
          d_acks++;
        end
        if (fetch_ack) f_ack_cyc = cyc;
        if (expq.size() == 0) begin
          check("ack_unexpected", {fetch_ack, data_ack}, 2'b00);
        end else begin
          e = expq.pop_front();
          check("ack_port_cycle", {data_ack, fetch_ack, 32'(cyc)},
                {e.is_data, ~e.is_data, 32'(e.cyc)});
          if (!e.is_data) m_fdata = e.data;
          else if (!e.is_store) m_rdata = e.data;
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        check("ack_missing", {fetch_ack, data_ack}, {~e.is_data, e.is_data});
      end
      if (mem_write_enable) we_cycles++;
      exp_me   = (cyc == g_cyc + 1);
      busy_exp = (cyc > g_cyc) && (cyc <= g_cyc + 2);
      check("mem_bus", {mem_enable, mem_write_enable, mem_address, mem_write_data, busy},
            exp_me ? {1'b1, g_we, g_addr, g_wdata, 1'b1}
                   : {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, busy_exp});
      check("read_regs", {fetch_data, data_rdata}, {m_fdata, m_rdata});
    end
    if (reset) begin
      expq.delete();
      g_cyc     = -100;
      next_free = cyc + 1;
      last_data = 1'b1;
      m_fdata   = '0;
      m_rdata   = '0;
      mon_en    = 1'b1;
    end else if (cyc >= next_free && (fetch_req || data_req)) begin
      if (fetch_req && data_req) win_data = RrEn ? !last_data : 1'b1;
      else win_data = data_req;
      last_data = win_data;
      g_cyc     = cyc;
      next_free = cyc + 3;
      e.is_data = win_data;
      e.cyc     = cyc + 2;
      if (win_data) begin
        g_addr     = data_addr;
        g_we       = data_we;
        g_wdata    = data_wdata;
        e.is_store = data_we;
        if (data_we) begin
          ref_mem[data_addr] = data_wdata;
          e.data = '0;
        end else begin
          e.data = ref_mem[data_addr];
        end
      end else begin
        g_addr     = fetch_addr;
        g_we       = 1'b0;
        g_wdata    = '0;
        e.is_store = 1'b0;
        e.data     = ref_mem[fetch_addr];
      end
      expq.push_back(e);
    end
  end

  // Requester tasks start and end at posedge+1 and hold the request until the ack.
  task automatic fetch_txn(input logic [AW-1:0] a);
    int n = 0;
    fetch_req  = 1'b1;
    fetch_addr = a;
    do begin
      @(negedge clock);
      n++;
    end while (!fetch_ack && n < 100);
    if (!fetch_ack) check("fetch_timeout", 64'(fetch_ack), 64'(1));
    @(posedge clock);
    #1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
  endtask

  task automatic data_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n = 0;
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = a;
    data_wdata = wd;
    do begin
      @(negedge clock);
      n++;
    end while (!data_ack && n < 100);
    if (!data_ack) check("data_timeout", 64'(data_ack), 64'(1));
    @(posedge clock);
    #1;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc;
    int da;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 16'h1234;
    ref_mem[8'h10] = 16'h1234;
    mem[8'hFF] = 16'hA5A5;
    ref_mem[8'hFF] = 16'hA5A5;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", {fetch_ack, data_ack, busy, mem_enable, mem_write_enable,
                            mem_address, fetch_data}, '0);
    check("reset_outputs2", {mem_write_data, data_rdata}, '0);
    @(posedge clock);
    #1;

    fetch_txn(8'h10);
    check("fetch_0x10", fetch_data, 16'h1234);

    wc = we_cycles;
    da = d_acks;
    data_txn(1'b1, 8'h20, 16'hBEEF);
    check("store_we_cycles", we_cycles - wc, 1);
    data_txn(1'b0, 8'h20, 16'h0000);
    check("load_after_store", data_rdata, 16'hBEEF);
    check("data_ack_count", d_acks - da, 2);

    do_reset();
    fork
      fetch_txn(8'h01);
      data_txn(1'b0, 8'h02, 16'h0000);
    join
    check("contention_gap", f_ack_cyc - d_ack_cyc, RrEn ? -3 : 3);

    do_reset();
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) fetch_txn(8'(8'h40 + i));
      end
      begin
        for (int j = 0; j < 6; j++) data_txn(1'b0, 8'(8'h30 + j), 16'h0000);
      end
    join
    check("contention_count", ack_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("contention_order_%0d", i), 64'(ack_log[i]),
            64'(RrEn ? (i % 2 == 1) : (i < 6)));
    end

    data_txn(1'b0, 8'hFF, 16'h0000);
    check("load_ff", data_rdata, 16'hA5A5);
    data_txn(1'b1, 8'h80, 16'h1111);
    check("rdata_after_store", data_rdata, 16'hA5A5);

    // Reset lands on the edge that ends the store's grant cycle.
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 8'hFF;
    data_wdata = 16'h5A5A;
    @(posedge clock);
    #1;
    check("grant_store_we", {mem_enable, mem_write_enable, mem_address}, {2'b11, 8'hFF});
    reset      = 1'b1;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_in_grant_mem", mem[8'hFF], 16'h5A5A);
    check("reset_in_grant_outputs", {fetch_ack, data_ack, busy, mem_enable, mem_write_enable,
                                     mem_address, mem_write_data, data_rdata}, '0);
    @(posedge clock);
    #1;
    data_txn(1'b0, 8'hFF, 16'h0000);
    check("load_after_reset_store", data_rdata, 16'h5A5A);

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          fetch_txn(8'($urandom_range(0, 127)));
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          logic          we;
          logic [AW-1:0] a;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          we = 1'($urandom_range(0, 1));
          a  = we ? 8'($urandom_range(128, 255)) : 8'($urandom);
          data_txn(we, a, 16'($urandom));
        end
      end
    join

    repeat (5) @(posedge clock);
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
